// File: rtl/i2s_dac_serializer.sv
// I2S DAC serializer: buffers one mono sample and sends it in both slots of each 64-BCLK frame.
// Define I2S_UNDERRUN_CNT_EN to add the saturating underrun_cnt output.
module i2s_dac_serializer #(
  parameter int BCLK_DIV = 8,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk_50m,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                sample_req,
  output logic                underrun,
  input  logic                underrun_clr,
  output logic                aud_bclk,
  output logic                aud_daclrck,
  output logic                aud_dacdat
`ifdef I2S_UNDERRUN_CNT_EN
  ,
  output logic [7:0]          underrun_cnt
`endif
);

  localparam int PRE_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BCLK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);
  localparam logic [4:0] LAST_POS = 5'(SAMPLE_W);

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic                bclk_q, bclk_d;
  logic [5:0]          bit_cnt_q, bit_cnt_d;
  logic                lrck_q, lrck_d;
  logic                dat_q, dat_d;
  logic [SAMPLE_W-1:0] frame_q, frame_d;
  logic [SAMPLE_W-1:0] hold_q, hold_d;
  logic [SAMPLE_W-1:0] last_q, last_d;
  logic                ready_q, ready_d;
  logic                req_q, req_d;
  logic                urun_q, urun_d;

  logic                presc_tc_s;
  logic                fe_s;
  logic                wrap_s;
  logic                accept_s;
  logic                urun_evt_s;
  logic [5:0]          bit_cnt_inc_s;

  // Slot position 0 is the I2S delay bit; positions 1..SAMPLE_W carry the word MSB first.
  function automatic logic slot_bit(input logic [SAMPLE_W-1:0] word, input logic [4:0] pos);
    logic [SAMPLE_W-1:0] shifted;
    shifted = word << (pos - 5'd1);
    if ((pos != 5'd0) && (pos <= LAST_POS)) begin
      slot_bit = shifted[SAMPLE_W-1];
    end else begin
      slot_bit = 1'b0;
    end
  endfunction

  assign presc_tc_s    = (presc_q == PRE_LAST);
  assign fe_s          = presc_tc_s & bclk_q;
  assign wrap_s        = fe_s & (bit_cnt_q == 6'd63);
  assign accept_s      = s_valid & ready_q;
  assign urun_evt_s    = wrap_s & ready_q;
  assign bit_cnt_inc_s = bit_cnt_q + 6'd1;

  // Next-state for clock generation, frame load, handshake and serial data.
  always_comb begin
    presc_d = presc_tc_s ? {PRE_W{1'b0}} : (presc_q + PRE_ONE);
    bclk_d  = presc_tc_s ? ~bclk_q : bclk_q;
    last_d  = last_q;
    ready_d = ready_q;
    req_d   = 1'b0;
    if (wrap_s && !ready_q) begin
      frame_d = hold_q;
      last_d  = hold_q;
      ready_d = 1'b1;
      req_d   = 1'b1;
    end else if (wrap_s) begin
      frame_d = last_q;
    end else begin
      frame_d = frame_q;
    end
    // A load that found the register empty may coincide with an accept; the new word waits a frame.
    if (accept_s) begin
      hold_d  = s_data;
      ready_d = 1'b0;
    end else begin
      hold_d  = hold_q;
    end
    if (fe_s) begin
      bit_cnt_d = bit_cnt_inc_s;
      lrck_d    = bit_cnt_inc_s[5];
      dat_d     = slot_bit(frame_d, bit_cnt_inc_s[4:0]);
    end else begin
      bit_cnt_d = bit_cnt_q;
      lrck_d    = lrck_q;
      dat_d     = dat_q;
    end
    if (underrun_clr) begin
      urun_d = 1'b0;
    end else if (urun_evt_s) begin
      urun_d = 1'b1;
    end else begin
      urun_d = urun_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      presc_q   <= {PRE_W{1'b0}};
      bclk_q    <= 1'b0;
      bit_cnt_q <= 6'd0;
      lrck_q    <= 1'b0;
      dat_q     <= 1'b0;
      frame_q   <= {SAMPLE_W{1'b0}};
      hold_q    <= {SAMPLE_W{1'b0}};
      last_q    <= {SAMPLE_W{1'b0}};
      ready_q   <= 1'b1;
      req_q     <= 1'b0;
      urun_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
      lrck_q    <= lrck_d;
      dat_q     <= dat_d;
      frame_q   <= frame_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
      ready_q   <= ready_d;
      req_q     <= req_d;
      urun_q    <= urun_d;
    end
  end

`ifdef I2S_UNDERRUN_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Saturating count of underrun frames; clear beats increment.
  always_comb begin
    if (underrun_clr) begin
      cnt_d = 8'd0;
    end else if (urun_evt_s && (cnt_q != 8'd255)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Underrun counter register.
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign underrun_cnt = cnt_q;
`endif

  assign s_ready     = ready_q;
  assign sample_req  = req_q;
  assign underrun    = urun_q;
  assign aud_bclk    = bclk_q;
  assign aud_daclrck = lrck_q;
  assign aud_dacdat  = dat_q;

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// Bench for i2s_dac_serializer: cycle-level reference model, codec-style receiver, vector table and sequences.
module tb_i2s_dac_serializer;

  logic        clk_50m = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] s_data = 16'h0000;
  logic        s_valid = 1'b0;
  logic        underrun_clr = 1'b0;
  logic        s_ready, sample_req, underrun, aud_bclk, aud_daclrck, aud_dacdat;
`ifdef I2S_UNDERRUN_CNT_EN
  logic [7:0]  underrun_cnt;
`endif

  i2s_dac_serializer #(.BCLK_DIV(8), .SAMPLE_W(16)) dut (
    .clk_50m(clk_50m), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .sample_req(sample_req), .underrun(underrun),
    .underrun_clr(underrun_clr), .aud_bclk(aud_bclk), .aud_daclrck(aud_daclrck),
    .aud_dacdat(aud_dacdat)
`ifdef I2S_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  always #10 clk_50m = ~clk_50m;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 20) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: n = clk edges since reset release; one frame = 1024 clk, one BCLK = 16 clk.
  int          n;
  bit          pend_v;
  logic [15:0] pend, last, frame;
  bit          m_und, m_req;
  int          m_cnt;

  task automatic m_reset();
    n = 0; pend_v = 0; pend = 16'h0; last = 16'h0; frame = 16'h0;
    m_und = 0; m_req = 0; m_cnt = 0;
  endtask

  task automatic m_step();
    bit was_empty, evt;
    was_empty = !pend_v;
    evt = 0;
    n++;
    m_req = 0;
    if (n % 1024 == 0) begin
      if (pend_v) begin
        frame = pend; last = pend; pend_v = 0; m_req = 1;
      end else begin
        frame = last; evt = 1;
      end
    end
    if (underrun_clr) begin
      m_und = 0; m_cnt = 0;
    end else if (evt) begin
      m_und = 1;
      if (m_cnt < 255) m_cnt++;
    end
    if (s_valid && was_empty) begin
      pend = s_data; pend_v = 1;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk_50m or negedge reset_n);
      if (!reset_n) m_reset();
      else m_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    int p;
    logic e_dat;
    forever begin
      @(negedge clk_50m);
      if (chk_en) begin
        p = (n / 16) % 32;
        e_dat = (p >= 1 && p <= 16) ? frame[16 - p] : 1'b0;
        chk("bclk", aud_bclk, ((n / 8) % 2) != 0);
        chk("daclrck", aud_daclrck, ((n / 512) % 2) != 0);
        chk("dacdat", aud_dacdat, e_dat);
        chk("s_ready", s_ready, !pend_v);
        chk("sample_req", sample_req, m_req);
        chk("underrun", underrun, m_und);
`ifdef I2S_UNDERRUN_CNT_EN
        chk("underrun_cnt", underrun_cnt, 8'(m_cnt));
`endif
      end
    end
  end

  // Codec-style receiver: samples DACDAT on BCLK rise, one delay bit after each LRCK change.
  logic [16:0] rx_q[$];
  initial begin
    logic pb, last_lr;
    logic [15:0] sh;
    int pos;
    pb = 0; last_lr = 0; pos = -1; sh = 16'h0;
    forever begin
      @(negedge clk_50m);
      if (!reset_n) begin
        pb = 0; last_lr = 0; pos = -1;
      end else begin
        if (aud_bclk && !pb) begin
          if (aud_daclrck != last_lr) pos = 0;
          else pos++;
          last_lr = aud_daclrck;
          if (pos >= 1 && pos <= 16) begin
            sh = {sh[14:0], aud_dacdat};
            if (pos == 16) rx_q.push_back({aud_daclrck, sh});
          end
        end
        pb = aud_bclk;
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk_50m);
  endtask

  task automatic wait_phase(input int ph);
    bit ok;
    ok = 0;
    for (int i = 0; i < 2100; i++) begin
      if (n % 1024 == ph) begin ok = 1; break; end
      @(negedge clk_50m);
    end
    chk("wait_phase_timeout", ok, 1'b1);
  endtask

  task automatic push(input logic [15:0] d);
    bit ok, rdy;
    ok = 0;
    s_data = d;
    s_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rdy = s_ready;
      @(negedge clk_50m);
      if (rdy) begin ok = 1; break; end
    end
    s_valid = 1'b0;
    chk("push_timeout", ok, 1'b1);
  endtask

  task automatic wait_req();
    bit ok;
    ok = 0;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk_50m);
      if (sample_req) begin ok = 1; break; end
    end
    chk("wait_req_timeout", ok, 1'b1);
  endtask

  task automatic get_words(output logic [16:0] l, output logic [16:0] r);
    int base;
    bit ok;
    base = rx_q.size();
    ok = 0;
    for (int i = 0; i < 2200; i++) begin
      if (rx_q.size() >= base + 2) begin ok = 1; break; end
      @(negedge clk_50m);
    end
    chk("rx_timeout", ok, 1'b1);
    if (ok) begin l = rx_q[base]; r = rx_q[base + 1]; end
    else begin l = 17'h0; r = 17'h0; end
  endtask

  typedef struct {
    logic [15:0] data;
    logic [15:0] bits;
  } vec_t;

  initial begin
    vec_t tbl[5];
    logic [16:0] wl, wr;
    int rises, hi, rate;
    logic pb;

    tbl[0] = '{16'hA5C3, 16'b1010_0101_1100_0011};
    tbl[1] = '{16'h8000, 16'b1000_0000_0000_0000};
    tbl[2] = '{16'h0001, 16'b0000_0000_0000_0001};
    tbl[3] = '{16'h7FFE, 16'b0111_1111_1111_1110};
    tbl[4] = '{16'h3C5A, 16'b0011_1100_0101_1010};

    tick(4);
    reset_n = 1'b1;
    chk_en = 1'b1;

    // Idle after reset: clock periods, duty, zero data, underrun after the first frame.
    rises = 0; hi = 0; pb = aud_bclk;
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk_50m);
      if (aud_bclk && !pb) rises++;
      if (aud_daclrck) hi++;
      pb = aud_bclk;
    end
    chk("bclk_rises_2048clk", 17'(rises), 17'd128);
    chk("lrck_high_2048clk", 17'(hi), 17'd1024);
    chk("idle_underrun", underrun, 1'b1);
    get_words(wl, wr);
    chk("idle_left", wl, 17'h00000);
    chk("idle_right", wr, 17'h10000);

    // Vector table: one sample per entry, checked in both slots.
    for (int v = 0; v < 5; v++) begin
      push(tbl[v].data);
      chk("ready_drop", s_ready, 1'b0);
      wait_req();
      get_words(wl, wr);
      chk("vec_left", wl, {1'b0, tbl[v].bits});
      chk("vec_right", wr, {1'b1, tbl[v].bits});
    end

    // Producer always valid: 1, 2, 3 in order, no underrun.
    underrun_clr = 1'b1; tick(1); underrun_clr = 1'b0;
    push(16'd1); push(16'd2); push(16'd3);
    wait_req();
    get_words(wl, wr);
    chk("stream_left", wl, 17'h00003);
    chk("stream_right", wr, 17'h10003);
    chk("stream_underrun", underrun, 1'b0);

    // Single 8000 then starve: repeat and underrun; clear wins over a new underrun.
    push(16'h8000);
    wait_req();
    wait_phase(1023); tick(1);
    chk("starve_underrun", underrun, 1'b1);
    get_words(wl, wr);
    chk("repeat_left", wl, 17'h08000);
    chk("repeat_right", wr, 17'h18000);
    wait_phase(1023);
    underrun_clr = 1'b1; tick(1); underrun_clr = 1'b0;
    chk("clr_wins", underrun, 1'b0);

    // Sample offered exactly at a load from empty: repeat now, new sample next frame.
    wait_phase(1023);
    s_data = 16'h1234; s_valid = 1'b1;
    tick(1);
    s_valid = 1'b0;
    chk("collide_underrun", underrun, 1'b1);
    chk("collide_ready", s_ready, 1'b0);
    get_words(wl, wr);
    chk("collide_repeat_left", wl, 17'h08000);
    chk("collide_repeat_right", wr, 17'h18000);
    wait_req();
    get_words(wl, wr);
    chk("collide_new_left", wl, 17'h01234);
    chk("collide_new_right", wr, 17'h11234);

    // Reset in the middle of a frame (bit 20, BCLK high, sample pending).
    wait_phase(20 * 16 + 10);
    push(16'hBEEF);
    tick(1);
    #3 reset_n = 1'b0;
    #1;
    chk("rst_bclk", aud_bclk, 1'b0);
    chk("rst_lrck", aud_daclrck, 1'b0);
    chk("rst_dat", aud_dacdat, 1'b0);
    chk("rst_req", sample_req, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_ready", s_ready, 1'b1);
    @(negedge clk_50m);
    tick(3);
    reset_n = 1'b1;
    get_words(wl, wr);
    chk("post_rst_left", wl, 17'h00000);
    chk("post_rst_right", wr, 17'h10000);

    // Random producer rates and occasional clears against the model.
    for (int f = 0; f < 12; f++) begin
      rate = int'($urandom_range(0, 3));
      for (int c = 0; c < 1024; c++) begin
        case (rate)
          0: s_valid = 1'b0;
          1: s_valid = ($urandom_range(0, 2047) == 0);
          2: s_valid = ($urandom_range(0, 255) == 0);
          default: s_valid = 1'b1;
        endcase
        s_data = 16'($urandom);
        underrun_clr = ($urandom_range(0, 511) == 0);
        @(negedge clk_50m);
      end
    end
    s_valid = 1'b0;
    underrun_clr = 1'b0;
    tick(10);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
